slurm16_cpu_mem_arbiter: RTL and testbench
==========================================

// Module: slurm16_cpu_mem_arbiter
// PURPOSE
//  Parametrised N-channel arbiter that multiplexes CPU requesters onto one memory port.
//  Requesters include instruction fetch, load/store and a future DMA/debug channel.
//  Sits between the pipeline/memory-interface logic and the external memory bus.
//  Adds round-robin or fixed-priority arbitration, a one-deep issue register and
//  fixed-latency read-data routing back to the issuing channel.
// PARAMETERS
//  NUM_CH        2   number of requesting channels (2..8); channel 0 has the highest fixed priority
//  ADDRESS_BITS  16  memory address width
//  BITS          16  data width (BITS/8 byte lanes)
//  MEM_LATENCY   1   cycles from an accepted read to valid memory_in (1..4)
//  ARB_MODE      0   0 = round-robin; 1 = fixed priority (lowest index wins)
// PORTS
//  CLK             in   1                     clock
//  RSTb            in   1                     asynchronous active-low reset
//  ch_req          in   NUM_CH                per-channel request; held stable until ch_ack
//  ch_wr           in   NUM_CH                1 = write, 0 = read
//  ch_address      in   NUM_CH*ADDRESS_BITS   flattened; channel i at [i*ADDRESS_BITS +: ADDRESS_BITS]
//  ch_wdata        in   NUM_CH*BITS           flattened write data
//  ch_wr_mask      in   NUM_CH*BITS/8         flattened byte-lane write mask
//  ch_ack          out  NUM_CH                one-hot pulse: request captured into the issue register
//  ch_rvalid       out  NUM_CH                one-hot pulse: ch_rdata is valid for this channel
//  ch_rdata        out  BITS                  read data, shared by all channels
//  memory_address  out  ADDRESS_BITS          to the memory bus
//  memory_out      out  BITS                  write data
//  memory_wr_mask  out  BITS/8                byte mask
//  memory_wr       out  1                     write strobe
//  memory_rd       out  1                     read strobe
//  memory_in       in   BITS                  read data, MEM_LATENCY cycles after acceptance
//  memory_success  in   1                     memory accepts the presented request this cycle
// BEHAVIOUR
//  - Reset (RSTb low, async): all outputs are 0, issue register is empty, RR pointer = 0,
//    and the return pipe is cleared. In-flight reads are dropped and no rvalid is produced later.
//  - Issue register (valid, ch, wr, addr, data, mask) drives the memory_* outputs directly.
//    memory_rd = valid & ~wr; memory_wr = valid & wr. Both are 0 when the register is empty.
//  - Accept: accept = valid & memory_success. Load: load = (~valid | accept) & |ch_req.
//    On load, the winner w is captured and ch_ack[w] = 1 in the same cycle (combinational).
//    Other channels are not acked and keep requesting.
//  - With valid set and memory_success low: the outputs hold and no ch_ack is given (stall).
//  - Back-to-back: accept and load in the same cycle give one transaction per cycle.
//    Latency from ch_req to memory strobe is 1 cycle when idle.
//  - Round-robin: search order is ptr, ptr+1, ... modulo NUM_CH. After each load, ptr = w+1 (wraps).
//    Fixed mode: lowest-index requester wins and ptr is unused.
//  - Return pipe: a MEM_LATENCY-deep shift of {rd_valid, ch}, advancing every cycle.
//    Entry = accept & ~wr. At the tail: ch_rvalid[ch] = 1 and ch_rdata = memory_in, both combinational.
//    Writes never enter the pipe. Stalls do not delay data that has already been accepted.
//  - ch_rdata is 0 when no rvalid is asserted.
//  - A channel may re-request in the cycle after its ack. Ordering per channel is preserved.
//  - A request that drops before its ack is a protocol violation: behaviour is undefined, and the bench asserts on it.
// STRUCTURE
//  - Shared package slurm16_mem_pkg holds localparams ARB_RR = 0, ARB_FIXED = 1
//    and function clog2_min1(n) for the channel-index width.
//  - One sub-module: slurm16_rr_arbiter (NUM_CH; req, ptr, mode -> one-hot grant plus index), combinational.
//  - Top level: issue register, RR pointer, return shift pipe, field muxing of the flattened buses.
// TESTING
//  1. Reset mid-read: ch0 reads 0x1000 (accepted), RSTb pulses low before the data returns
//     -> all outputs 0, no ch_rvalid afterwards.
//  2. Single read (NUM_CH=2, LAT=1): ch1 reads 0x2000 and memory_in = 0xBEEF at the return cycle
//     -> ch_ack=2'b10 at t0, memory_rd with addr 0x2000 at t1, ch_rvalid=2'b10 and ch_rdata=0xBEEF at t2.
//  3. Round-robin fairness: ch0 and ch1 request continuously, memory_success=1
//     -> acks alternate 01, 10, 01, 10; each channel gets 50% of grants over 100 cycles.
//  4. Fixed priority (ARB_MODE=1, NUM_CH=4): ch0..3 all request continuously -> only ch0 acked;
//     drop ch0 -> ch1 acked next cycle.
//  5. Stall: memory_success=0 for 3 cycles with a write to 0x3000, mask 2'b01 pending
//     -> outputs held 3 cycles, no ch_ack; accepted on cycle 4 and the next request loads the same cycle.
//  6. Latency routing (MEM_LATENCY=3, NUM_CH=3): reads from ch2, ch0, ch1 on consecutive cycles
//     -> rvalid 100, 001, 010 on cycles +3, +4, +5 with the matching memory_in values.

Source files
------------

// File: rtl/slurm16_mem_pkg.sv
// Shared constants and helpers for the slurm16 memory-side blocks.
package slurm16_mem_pkg;

  localparam int unsigned ARB_RR    = 0;
  localparam int unsigned ARB_FIXED = 1;

  // Width of a channel index; a single channel still gets a 1-bit index.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < n) w++;
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/slurm16_rr_arbiter.sv
// Combinational N-way arbiter: round-robin from ptr, or fixed lowest-index priority.
module slurm16_rr_arbiter
  import slurm16_mem_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned IW     = clog2_min1(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IW-1:0]     ptr,
  input  logic              mode,
  output logic [NUM_CH-1:0] grant,
  output logic [IW-1:0]     idx
);

  always_comb begin : arb
    int unsigned cand;
    logic        found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    // Walk candidates in priority order; the inner loop keeps every select constant.
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      cand = mode ? k : ((32'(ptr) + k) % NUM_CH);
      for (int unsigned j = 0; j < NUM_CH; j++) begin
        if (!found && (j == cand) && req[j]) begin
          grant[j] = 1'b1;
          idx      = IW'(j);
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/slurm16_cpu_mem_arbiter.sv
// N-channel CPU memory arbiter: one-deep issue register onto the memory port and
// fixed-latency routing of read data back to the channel that issued it.
module slurm16_cpu_mem_arbiter
  import slurm16_mem_pkg::*;
#(
  parameter int unsigned NUM_CH       = 2,
  parameter int unsigned ADDRESS_BITS = 16,
  parameter int unsigned BITS         = 16,
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned ARB_MODE     = ARB_RR
) (
  input  logic                           CLK,
  input  logic                           RSTb,
  input  logic [NUM_CH-1:0]              ch_req,
  input  logic [NUM_CH-1:0]              ch_wr,
  input  logic [NUM_CH*ADDRESS_BITS-1:0] ch_address,
  input  logic [NUM_CH*BITS-1:0]         ch_wdata,
  input  logic [NUM_CH*(BITS/8)-1:0]     ch_wr_mask,
  output logic [NUM_CH-1:0]              ch_ack,
  output logic [NUM_CH-1:0]              ch_rvalid,
  output logic [BITS-1:0]                ch_rdata,
  output logic [ADDRESS_BITS-1:0]        memory_address,
  output logic [BITS-1:0]                memory_out,
  output logic [BITS/8-1:0]              memory_wr_mask,
  output logic                           memory_wr,
  output logic                           memory_rd,
  input  logic [BITS-1:0]                memory_in,
  input  logic                           memory_success
);

  localparam int unsigned IW = clog2_min1(NUM_CH);
  localparam int unsigned MW = BITS / 8;

  logic                    valid_q, valid_d;
  logic [IW-1:0]           ch_q, ch_d;
  logic                    wr_q, wr_d;
  logic [ADDRESS_BITS-1:0] addr_q, addr_d;
  logic [BITS-1:0]         data_q, data_d;
  logic [MW-1:0]           mask_q, mask_d;
  logic [IW-1:0]           ptr_q, ptr_d;

  logic [MEM_LATENCY-1:0]         rp_vld_q, rp_vld_d;
  logic [MEM_LATENCY-1:0][IW-1:0] rp_ch_q, rp_ch_d;

  logic [NUM_CH-1:0] grant;
  logic [IW-1:0]     win_idx;
  logic              accept;
  logic              load;
  logic              tail_vld;
  logic [IW-1:0]     tail_ch;

  slurm16_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IW     (IW)
  ) u_arb (
    .req   (ch_req),
    .ptr   (ptr_q),
    .mode  (ARB_MODE == ARB_FIXED),
    .grant (grant),
    .idx   (win_idx)
  );

  assign accept = valid_q & memory_success;
  assign load   = (~valid_q | accept) & (|ch_req);

  always_comb begin
    valid_d = valid_q;
    ch_d    = ch_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mask_d  = mask_q;
    ptr_d   = ptr_q;
    if (load) begin
      valid_d = 1'b1;
      ch_d    = win_idx;
      wr_d    = ch_wr[win_idx];
      addr_d  = ch_address[32'(win_idx)*ADDRESS_BITS +: ADDRESS_BITS];
      data_d  = ch_wdata[32'(win_idx)*BITS +: BITS];
      mask_d  = ch_wr_mask[32'(win_idx)*MW +: MW];
      if (ARB_MODE == ARB_RR)
        ptr_d = (win_idx == IW'(NUM_CH - 1)) ? '0 : win_idx + 1'b1;
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  // Return pipe shifts every cycle regardless of stalls; only accepted reads enter.
  always_comb begin
    rp_vld_d    = '0;
    rp_ch_d     = '0;
    rp_vld_d[0] = accept & ~wr_q;
    rp_ch_d[0]  = ch_q;
    for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
      rp_vld_d[i] = rp_vld_q[i-1];
      rp_ch_d[i]  = rp_ch_q[i-1];
    end
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      valid_q  <= 1'b0;
      ch_q     <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      mask_q   <= '0;
      ptr_q    <= '0;
      rp_vld_q <= '0;
      rp_ch_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      ch_q     <= ch_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      mask_q   <= mask_d;
      ptr_q    <= ptr_d;
      rp_vld_q <= rp_vld_d;
      rp_ch_q  <= rp_ch_d;
    end
  end

  assign tail_vld = rp_vld_q[MEM_LATENCY-1];
  assign tail_ch  = rp_ch_q[MEM_LATENCY-1];

  always_comb begin
    ch_ack    = (load && RSTb) ? grant : '0;
    ch_rvalid = '0;
    ch_rdata  = '0;
    if (tail_vld) begin
      ch_rvalid[tail_ch] = 1'b1;
      ch_rdata           = memory_in;
    end
  end

  assign memory_address = addr_q;
  assign memory_out     = data_q;
  assign memory_wr_mask = mask_q;
  assign memory_wr      = valid_q & wr_q;
  assign memory_rd      = valid_q & ~wr_q;

endmodule

// File: tb/tb_slurm16_cpu_mem_arbiter.sv
// Directed bench for slurm16_cpu_mem_arbiter: three configurations sharing one clock and reset.
module tb_slurm16_cpu_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  // A: NUM_CH=2, round-robin, latency 1
  logic [1:0]  a_req = '0, a_wr = '0, a_ack, a_rvalid;
  logic [31:0] a_addr = '0, a_wdata = '0;
  logic [3:0]  a_mask = '0;
  logic [15:0] a_rdata, a_maddr, a_mout, a_min = 16'h5555;
  logic [1:0]  a_mmask;
  logic        a_mwr, a_mrd, a_succ = 1'b1;

  // B: NUM_CH=4, fixed priority, latency 1
  logic [3:0]  b_req = '0, b_wr = '0, b_ack, b_rvalid;
  logic [63:0] b_addr = '0, b_wdata = '0;
  logic [7:0]  b_mask = '0;
  logic [15:0] b_rdata, b_maddr, b_mout, b_min = '0;
  logic [1:0]  b_mmask;
  logic        b_mwr, b_mrd, b_succ = 1'b1;

  // C: NUM_CH=3, round-robin, latency 3
  logic [2:0]  c_req = '0, c_wr = '0, c_ack, c_rvalid;
  logic [47:0] c_addr = '0, c_wdata = '0;
  logic [5:0]  c_mask = '0;
  logic [15:0] c_rdata, c_maddr, c_mout, c_min = '0;
  logic [1:0]  c_mmask;
  logic        c_mwr, c_mrd, c_succ = 1'b1;

  slurm16_cpu_mem_arbiter #(.NUM_CH(2), .ADDRESS_BITS(16), .BITS(16), .MEM_LATENCY(1), .ARB_MODE(0)) dut_a (
    .CLK(clk), .RSTb(rst_n), .ch_req(a_req), .ch_wr(a_wr), .ch_address(a_addr),
    .ch_wdata(a_wdata), .ch_wr_mask(a_mask), .ch_ack(a_ack), .ch_rvalid(a_rvalid),
    .ch_rdata(a_rdata), .memory_address(a_maddr), .memory_out(a_mout),
    .memory_wr_mask(a_mmask), .memory_wr(a_mwr), .memory_rd(a_mrd),
    .memory_in(a_min), .memory_success(a_succ));

  slurm16_cpu_mem_arbiter #(.NUM_CH(4), .ADDRESS_BITS(16), .BITS(16), .MEM_LATENCY(1), .ARB_MODE(1)) dut_b (
    .CLK(clk), .RSTb(rst_n), .ch_req(b_req), .ch_wr(b_wr), .ch_address(b_addr),
    .ch_wdata(b_wdata), .ch_wr_mask(b_mask), .ch_ack(b_ack), .ch_rvalid(b_rvalid),
    .ch_rdata(b_rdata), .memory_address(b_maddr), .memory_out(b_mout),
    .memory_wr_mask(b_mmask), .memory_wr(b_mwr), .memory_rd(b_mrd),
    .memory_in(b_min), .memory_success(b_succ));

  slurm16_cpu_mem_arbiter #(.NUM_CH(3), .ADDRESS_BITS(16), .BITS(16), .MEM_LATENCY(3), .ARB_MODE(0)) dut_c (
    .CLK(clk), .RSTb(rst_n), .ch_req(c_req), .ch_wr(c_wr), .ch_address(c_addr),
    .ch_wdata(c_wdata), .ch_wr_mask(c_mask), .ch_ack(c_ack), .ch_rvalid(c_rvalid),
    .ch_rdata(c_rdata), .memory_address(c_maddr), .memory_out(c_mout),
    .memory_wr_mask(c_mmask), .memory_wr(c_mwr), .memory_rd(c_mrd),
    .memory_in(c_min), .memory_success(c_succ));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // A request must stay up until acked.
  logic [1:0] a_pend = '0;
  logic [3:0] b_pend = '0;
  logic [2:0] c_pend = '0;
  always @(posedge clk) begin
    if (!rst_n) begin
      a_pend <= '0; b_pend <= '0; c_pend <= '0;
    end else begin
      if ((a_pend & ~a_req) != '0) $error("protocol: A request dropped before ack");
      if ((b_pend & ~b_req) != '0) $error("protocol: B request dropped before ack");
      if ((c_pend & ~c_req) != '0) $error("protocol: C request dropped before ack");
      a_pend <= a_req & ~a_ack;
      b_pend <= b_req & ~b_ack;
      c_pend <= c_req & ~c_ack;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] seen;
    logic [1:0] ack2;
    logic [3:0] ack4;
    int cnt0, cnt1;

    step(); step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ack", a_ack, 0);
    chk("rst_rd", a_mrd, 0);
    chk("rst_wr", a_mwr, 0);
    chk("rst_addr", a_maddr, 0);
    chk("rst_rvalid", a_rvalid, 0);
    chk("rst_rdata", a_rdata, 0);
    chk("rst_c_rvalid", c_rvalid, 0);

    // 1: reset while a read is in flight
    step();
    a_req = 2'b01; a_wr = 2'b00; a_addr[15:0] = 16'h1000;
    @(negedge clk); chk("t1_ack", a_ack, 2'b01);
    step(); a_req = 2'b00;
    @(negedge clk); chk("t1_rd", a_mrd, 1); chk("t1_addr", a_maddr, 16'h1000);
    step(); rst_n = 1'b0; #1;
    chk("t1_rst_rd", a_mrd, 0);
    chk("t1_rst_addr", a_maddr, 0);
    chk("t1_rst_rvalid", a_rvalid, 0);
    chk("t1_rst_rdata", a_rdata, 0);
    chk("t1_rst_ack", a_ack, 0);
    step(); rst_n = 1'b1;
    seen = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); seen |= a_rvalid;
      step();
    end
    chk("t1_no_rvalid", seen, 0);

    // 2: single read on ch1
    a_req = 2'b10; a_addr[31:16] = 16'h2000;
    @(negedge clk); chk("t2_ack", a_ack, 2'b10); chk("t2_rd_idle", a_mrd, 0);
    step(); a_req = 2'b00;
    @(negedge clk); chk("t2_rd", a_mrd, 1); chk("t2_addr", a_maddr, 16'h2000); chk("t2_ack0", a_ack, 0);
    step(); a_min = 16'hBEEF;
    @(negedge clk); chk("t2_rvalid", a_rvalid, 2'b10); chk("t2_rdata", a_rdata, 16'hBEEF);
    step();
    @(negedge clk); chk("t2_rvalid_off", a_rvalid, 0); chk("t2_rdata_zero", a_rdata, 0);
    step(); a_min = 16'h5555;

    // 3: round-robin fairness over 100 cycles
    a_req = 2'b11; a_wr = 2'b00;
    cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i < 4) chk("t3_alt", a_ack, (i % 2 == 0) ? 2'b01 : 2'b10);
      cnt0 += int'(a_ack[0]);
      cnt1 += int'(a_ack[1]);
      step();
    end
    chk("t3_cnt0", cnt0, 50);
    chk("t3_cnt1", cnt1, 50);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); ack2 = a_ack;
      step(); a_req &= ~ack2;
      if (a_req == '0) break;
    end
    step(); step();

    // 5: stalled write, then back-to-back accept and load
    a_succ = 1'b0;
    a_req = 2'b01; a_wr = 2'b01; a_addr[15:0] = 16'h3000;
    a_wdata[15:0] = 16'h1234; a_mask[1:0] = 2'b01;
    @(negedge clk); chk("t5_ack", a_ack, 2'b01);
    step();
    a_req = 2'b10; a_wr = 2'b00; a_addr[31:16] = 16'h4000;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("t5_hold_wr", a_mwr, 1);
      chk("t5_hold_addr", a_maddr, 16'h3000);
      chk("t5_hold_data", a_mout, 16'h1234);
      chk("t5_hold_mask", a_mmask, 2'b01);
      chk("t5_no_ack", a_ack, 0);
      step();
    end
    a_succ = 1'b1;
    @(negedge clk); chk("t5_acc_wr", a_mwr, 1); chk("t5_b2b_ack", a_ack, 2'b10);
    step(); a_req = 2'b00;
    @(negedge clk); chk("t5_rd", a_mrd, 1); chk("t5_rd_addr", a_maddr, 16'h4000); chk("t5_wr_off", a_mwr, 0);
    step(); a_min = 16'h4444;
    @(negedge clk); chk("t5_rvalid", a_rvalid, 2'b10); chk("t5_rdata", a_rdata, 16'h4444);
    step();

    // 4: fixed priority with four channels
    b_req = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("t4_ch0", b_ack, 4'b0001);
      step();
    end
    b_req = 4'b1110;
    @(negedge clk); chk("t4_ch1", b_ack, 4'b0010);
    step();
    @(negedge clk); chk("t4_ch1_again", b_ack, 4'b0010);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); ack4 = b_ack;
      step(); b_req &= ~ack4;
      if (b_req == '0) break;
    end
    step(); step();

    // 6: latency-3 routing on three channels
    c_addr[15:0] = 16'h0200; c_addr[31:16] = 16'h0211; c_addr[47:32] = 16'h0222;
    c_req = 3'b100;
    @(negedge clk); chk("t6_ack2", c_ack, 3'b100);
    step(); c_req = 3'b001;
    @(negedge clk); chk("t6_ack0", c_ack, 3'b001); chk("t6_addr2", c_maddr, 16'h0222); chk("t6_rd", c_mrd, 1);
    step(); c_req = 3'b010;
    @(negedge clk); chk("t6_ack1", c_ack, 3'b010); chk("t6_addr0", c_maddr, 16'h0200);
    step(); c_req = 3'b000;
    @(negedge clk); chk("t6_addr1", c_maddr, 16'h0211); chk("t6_early", c_rvalid, 0);
    step(); c_min = 16'h00A2;
    @(negedge clk); chk("t6_rv2", c_rvalid, 3'b100); chk("t6_rd2", c_rdata, 16'h00A2);
    step(); c_min = 16'h00A0;
    @(negedge clk); chk("t6_rv0", c_rvalid, 3'b001); chk("t6_rd0", c_rdata, 16'h00A0);
    step(); c_min = 16'h00A1;
    @(negedge clk); chk("t6_rv1", c_rvalid, 3'b010); chk("t6_rd1", c_rdata, 16'h00A1);
    step();
    @(negedge clk); chk("t6_done", c_rvalid, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
